// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: arbitrates two requesters (A, B) onto the single
// write port of register_file. Registered FSM (IDLE, WRITE_A, WRITE_B).
// A tie in IDLE is resolved round-robin using last_served. A requester is
// never granted on two consecutive cycles, so that it can see its ack.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req_x, addr_x, data_x    requester x write request (x = a, b)
//   ack_x                    one-cycle grant/complete pulse to requester x
//   reg_write, write_reg,
//   write_data               register_file write port
//   busy                     high while in WRITE_A or WRITE_B
//   conflict_cnt             saturating tie-decision count
//                            (present only with REGFILE_ARB_STATS_EN)
//
// Build option: define REGFILE_ARB_STATS_EN to add conflict_cnt.
module regfile_write_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [4:0]  addr_a,
  input  logic [23:0] data_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [4:0]  addr_b,
  input  logic [23:0] data_b,
  output logic        ack_b,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [23:0] write_data,
  output logic        busy
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [15:0] conflict_cnt
`endif
);

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE_A = 2'd1,
    WRITE_B = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_served_q, last_served_d;
  logic                reg_write_q, reg_write_d;
  logic                ack_a_q, ack_a_d;
  logic                ack_b_q, ack_b_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;

  // Next state, payload capture on entry, and registered output decode.
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    write_reg_d   = write_reg_q;
    write_data_d  = write_data_q;

    case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          // last_served = 1 means B went last, so A wins
          state_d = last_served_q ? WRITE_A : WRITE_B;
        end else if (req_a) begin
          state_d = WRITE_A;
        end else if (req_b) begin
          state_d = WRITE_B;
        end
      end
      // The granted requester has not seen its ack yet: ignore its req here.
      WRITE_A: state_d = req_b ? WRITE_B : IDLE;
      WRITE_B: state_d = req_a ? WRITE_A : IDLE;
      default: state_d = IDLE;
    endcase

    // Self-loops are impossible, so state_d == WRITE_x is always an entry.
    if (state_d == WRITE_A) begin
      write_reg_d   = addr_a;
      write_data_d  = data_a;
      last_served_d = 1'b0;
    end else if (state_d == WRITE_B) begin
      write_reg_d   = addr_b;
      write_data_d  = data_b;
      last_served_d = 1'b1;
    end

    reg_write_d = (state_d != IDLE);
    busy_d      = (state_d != IDLE);
    ack_a_d     = (state_d == WRITE_A);
    ack_b_d     = (state_d == WRITE_B);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      reg_write_q   <= 1'b0;
      ack_a_q       <= 1'b0;
      ack_b_q       <= 1'b0;
      busy_q        <= 1'b0;
      write_reg_q   <= '0;
      write_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      reg_write_q   <= reg_write_d;
      ack_a_q       <= ack_a_d;
      ack_b_q       <= ack_b_d;
      busy_q        <= busy_d;
      write_reg_q   <= write_reg_d;
      write_data_q  <= write_data_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign ack_a      = ack_a_q;
  assign ack_b      = ack_b_q;
  assign busy       = busy_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;

`ifdef REGFILE_ARB_STATS_EN
  localparam int unsigned CNT_W = 16;

  logic             tie_c;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  // Only IDLE can see two eligible requests; in WRITE_x one side is masked.
  assign tie_c = (state_q == IDLE) && req_a && req_b;

  // Saturating tie counter.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (tie_c && (conflict_cnt_q != {CNT_W{1'b1}})) begin
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, declared as the first two ports: clk and rst_n.
REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  input  1  rising-edge clock shared with register_file
- rst_n  input  1  asynchronous active-low reset
- req_a  input  1  requester A write request, held until ack_a
- addr_a  input  5  requester A destination register
- data_a  input  24  requester A write data
- ack_a  output  1  one-cycle grant/complete pulse to A
- req_b  input  1  requester B write request, held until ack_b
- addr_b  input  5  requester B destination register
- data_b  input  24  requester B write data
- ack_b  output  1  one-cycle grant/complete pulse to B
- reg_write  output  1  drives register_file reg_write
- write_reg  output  5  drives register_file write_reg
- write_data  output  24  drives register_file write_data
- busy  output  1  high while in WRITE_A or WRITE_B
- conflict_cnt  output  16  saturating conflict count (only with REGFILE_ARB_STATS_EN)

Function
REQ-003 The block SHALL be a registered FSM with states IDLE, WRITE_A, WRITE_B; all outputs SHALL be registered or decoded from state only.
REQ-004 In WRITE_x: reg_write=1, ack_x=1, the other ack=0, and write_reg/write_data hold the addr/data of x captured at the entry edge.
REQ-005 In IDLE: reg_write=0, ack_a=ack_b=0; write_reg/write_data hold their last values.
REQ-006 IDLE transitions: only req_a -> WRITE_A; only req_b -> WRITE_B; both -> requester not last served; neither -> IDLE.
REQ-007 WRITE_x transitions: req of the other requester high -> WRITE_other; otherwise -> IDLE; req_x SHALL be ignored at this edge because the requester has not yet observed ack_x.
REQ-008 Latency: a request sampled high in IDLE at edge N SHALL produce reg_write and ack one cycle later, with the register file write at edge N+1.
REQ-009 Throughput: alternating requests SHALL be served back-to-back (one write per cycle); the same requester SHALL be served at most every second cycle.
REQ-010 A last_served bit SHALL update on every entry to WRITE_A (0) or WRITE_B (1).
REQ-011 addr/data SHALL be sampled only on the edge entering WRITE_x; changes while ack is pending SHALL have no effect.
REQ-012 Requesters SHALL hold req, addr and data stable until ack; a deasserted req before ack is a withdrawal, and a withdrawn request SHALL NOT be granted.

Reset
REQ-013 While rst_n=0 the block SHALL be in IDLE with reg_write=0, ack_a=0, ack_b=0, busy=0, write_reg=0, write_data=0, last_served=1 (A wins first tie) and conflict_cnt=0.
REQ-014 Reset asserted mid-WRITE_x SHALL drop reg_write and ack_x immediately (asynchronous reset), and the write SHALL NOT be considered done.
REQ-015 After rst_n deasserts, the first rising edge SHALL evaluate IDLE transitions normally.

Configuration
REQ-016 The macro REGFILE_ARB_STATS_EN SHALL control conflict_cnt.
- Defined: conflict_cnt increments at every edge where the FSM chooses between two eligible requests (both req high and neither masked by REQ-007); it saturates at 16'hFFFF.
- Undefined: the conflict_cnt port and counter SHALL be absent, and arbitration behaviour SHALL be identical.

Verification
REQ-017 The bench SHALL cover these scenarios:
- Single A: req_a=1, addr_a=0, data_a=123 -> next cycle reg_write=1, ack_a=1, write_reg=0, write_data=123; register_file reads 123 on reg 0.
- Tie after reset: req_a and req_b both held (A: r3=0x00AAAA, B: r4=0x00BBBB) -> WRITE_A then WRITE_B on consecutive cycles; conflict_cnt=1.
- Round robin: both requests continuously re-issued for 6 grants -> grants alternate A,B,A,B,A,B; no state twice in a row.
- Lone repeat: only req_a held high continuously -> ack_a pulses every second cycle (WRITE_A, IDLE, WRITE_A ...).
- Reset mid-write: rst_n=0 during WRITE_B -> reg_write, ack_b, busy go 0 without a clock edge; after release, last_served=1 and state is IDLE.
- Saturation (macro defined): force 65,540 tie decisions -> conflict_cnt stops at 16'hFFFF; with macro undefined the design elaborates without the port.
